vedic_mul8_seq: RTL and testbench

- Sequential 8x8 unsigned multiplier with one shared 4x4 multiplier core.
- Computes 4 nibble partial products in successive cycles. Each is shifted and accumulated into a 16-bit result.
- Valid/ready handshake on both sides. Trades throughput for area: one multiplier core instead of four.
- Sits between the tile I/O wrapper and the 4x4 core.

---
 rtl/vedic_pkg.sv | 41 ++++
 rtl/mul4x4_core.sv | 23 ++
 rtl/vedic_mul8_seq.sv | 139 +++++++++++++
 tb/tb_vedic_mul8_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vedic_pkg
// Purpose : Shared types and constants for the sequential 8x8 multiplier.
//           FSM state encoding, datapath widths and the per-step shift
//           amounts applied to each nibble partial product.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package vedic_pkg;

  localparam int STEP_W = 2;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Shift applied to the partial product of each step:
  // step0 aL*bL, step1 aH*bL, step2 aL*bH, step3 aH*bH.
  localparam logic [3:0] SHIFT_STEP0 = 4'd0;
  localparam logic [3:0] SHIFT_STEP1 = 4'd4;
  localparam logic [3:0] SHIFT_STEP2 = 4'd4;
  localparam logic [3:0] SHIFT_STEP3 = 4'd8;

  function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = SHIFT_STEP0;
      2'd1:    sh = SHIFT_STEP1;
      2'd2:    sh = SHIFT_STEP2;
      default: sh = SHIFT_STEP3;
    endcase
    return sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul4x4_core.sv
`default_nettype none
// ============================================================================
// Module  : mul4x4_core
// Purpose : Purely combinational 4x4 unsigned multiplier, 8-bit product.
// Ports   : a_i [3:0]  multiplicand nibble
//           b_i [3:0]  multiplier nibble
//           p_o [7:0]  product a_i*b_i
// Revision: 1.0 - initial release
// ============================================================================
module mul4x4_core
  import vedic_pkg::*;
(
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  output logic [2*NIB_W-1:0] p_o
);

  // Operands are zero-extended first so the multiply is evaluated at the
  // full product width.
  assign p_o = {{NIB_W{1'b0}}, a_i} * {{NIB_W{1'b0}}, b_i};

endmodule
`default_nettype wire

// File: rtl/vedic_mul8_seq.sv
`default_nettype none
// ============================================================================
// Module  : vedic_mul8_seq
// Purpose : Sequential 8x8 unsigned multiplier built around a single shared
//           4x4 core. Four nibble partial products are formed on successive
//           enabled cycles, shifted and accumulated into a 16-bit result.
//           Optional macro VEDIC_ZERO_SKIP_EN: a zero operand at accept
//           bypasses the multiply steps and completes in one cycle.
// Ports   : clk_i, rst_ni        clock (rising), async active-low reset
//           en_i                 enable; low freezes sequencing
//           in_valid_i/in_ready_o, in_a_i, in_b_i, in_tag_i   request side
//           out_valid_o/out_ready_i, out_p_o, out_tag_o       result side
//           busy_o               high whenever the FSM is not idle
// Revision: 1.0 - initial release
// ============================================================================
module vedic_mul8_seq
  import vedic_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        in_a_i,
  input  logic [7:0]        in_b_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PROD_W-1:0] out_p_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic              busy_o
);

`ifdef VEDIC_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  state_t              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   acc_d;
  logic [7:0]          a_q;
  logic [7:0]          b_q;
  logic [TAG_W-1:0]    tag_q;
  logic                out_valid_q;
  logic [PROD_W-1:0]   out_p_q;
  logic [TAG_W-1:0]    out_tag_q;

  logic [NIB_W-1:0]    core_a;
  logic [NIB_W-1:0]    core_b;
  logic [2*NIB_W-1:0]  pp;

  // Core operands come only from registered operands, so there is no
  // combinational path from in_* to out_*. step[0] picks the high nibble
  // of a, step[1] the high nibble of b.
  always_comb begin
    core_a = step_q[0] ? a_q[7:4] : a_q[3:0];
    core_b = step_q[1] ? b_q[7:4] : b_q[3:0];
  end

  mul4x4_core u_core (
    .a_i (core_a),
    .b_i (core_b),
    .p_o (pp)
  );

  // Max total is 0xFE01, so the 16-bit sum never wraps.
  assign acc_d = acc_q + ({{(PROD_W-2*NIB_W){1'b0}}, pp} << step_shift(step_q));

  // Gated with rst_ni so in_ready reads low throughout reset.
  assign in_ready_o  = (state_q == ST_IDLE) && en_i && rst_ni;
  assign busy_o      = (state_q != ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_p_o     = out_p_q;
  assign out_tag_o   = out_tag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i && en_i) begin
            a_q    <= in_a_i;
            b_q    <= in_b_i;
            tag_q  <= in_tag_i;
            acc_q  <= '0;
            step_q <= '0;
            if (ZERO_SKIP && ((in_a_i == 8'd0) || (in_b_i == 8'd0))) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_p_q     <= '0;
              out_tag_q   <= in_tag_i;
            end else begin
              state_q <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (en_i) begin
            acc_q  <= acc_d;
            step_q <= step_q + 2'd1;
            if (step_q == 2'd3) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_p_q     <= acc_d;
              out_tag_q   <= tag_q;
            end
          end
        end
        ST_DONE: begin
          // Output handshake does not depend on en.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vedic_mul8_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_vedic_mul8_seq
// Purpose : Self-checking bench for vedic_mul8_seq: table of directed
//           vectors, hand-written multi-cycle sequences (backpressure, enable
//           stall, mid-operation reset) and a randomized scoreboard run.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vedic_mul8_seq;

  localparam int TAG_W = 2;

`ifdef VEDIC_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_p;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vedic_mul8_seq #(.TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_tag_i    (in_tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_p_o     (out_p),
    .out_tag_o   (out_tag),
    .busy_o      (busy)
  );

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
    logic [15:0]      p;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bounded wait for in_ready; all bench activity is aligned to negedges.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Presents one request; returns at the negedge just after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] t);
    wait_ready();
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid_low", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int pre;
    int exp_lat;
    logic [15:0]      exp_p_q[$];
    logic [TAG_W-1:0] exp_t_q[$];
    int sent;
    int got;
    int cyc;
    bit accepted;

    tbl[0] = '{8'hFF, 8'hFF, 2'd1, 16'hFE01};
    tbl[1] = '{8'h12, 8'h34, 2'd2, 16'h03A8};
    tbl[2] = '{8'h9C, 8'h07, 2'd3, 16'h0444};
    tbl[3] = '{8'h00, 8'hAB, 2'd0, 16'h0000};
    tbl[4] = '{8'h03, 8'h05, 2'd1, 16'h000F};
    tbl[5] = '{8'h01, 8'h01, 2'd2, 16'h0001};
    tbl[6] = '{8'hFF, 8'h00, 2'd3, 16'h0000};
    tbl[7] = '{8'h80, 8'h02, 2'd0, 16'h0100};

    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_p",     32'(out_p),     32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      exp_lat = (SKIP && (tbl[i].a == 8'd0 || tbl[i].b == 8'd0)) ? 0 : 4;
      issue(tbl[i].a, tbl[i].b, tbl[i].tag);
      if (exp_lat != 0) check($sformatf("tbl%0d_busy", i), 32'(busy), 32'd1);
      wait_out(lat);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(exp_lat));
      check($sformatf("tbl%0d_p", i),       32'(out_p), 32'(tbl[i].p));
      check($sformatf("tbl%0d_tag", i),     32'(out_tag), 32'(tbl[i].tag));
      drain();
      check($sformatf("tbl%0d_busy_after", i), 32'(busy), 32'd0);
    end

    // Backpressure: result held stable for 3 cycles with out_ready low
    issue(8'h12, 8'h34, 2'd2);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_p",        32'(out_p),     32'h03A8);
      check("bp_tag",      32'(out_tag),   32'd2);
      check("bp_in_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_same_cycle", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_valid_after",    32'(out_valid), 32'd0);

    // Enable dropped for 2 cycles during MUL
    issue(8'h9C, 8'h07, 2'd3);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("en_low_in_ready", 32'(in_ready), 32'd0);
      check("en_low_busy",     32'(busy),     32'd1);
      @(negedge clk);
    end
    en = 1'b1;
    pre = 3;
    wait_out(lat);
    check("en_latency", 32'(pre + lat), 32'd6);
    check("en_p",       32'(out_p),     32'h0444);
    check("en_tag",     32'(out_tag),   32'd3);
    drain();

    // Reset in the middle of an operation
    issue(8'hAA, 8'h55, 2'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid",    32'(out_valid), 32'd0);
    check("midrst_busy",     32'(busy),      32'd0);
    check("midrst_in_ready", 32'(in_ready),  32'd0);
    check("midrst_out_p",    32'(out_p),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("postrst_valid", 32'(out_valid), 32'd0);
    issue(8'h03, 8'h05, 2'd2);
    wait_out(lat);
    check("postrst_latency", 32'(lat),     32'd4);
    check("postrst_p",       32'(out_p),   32'h000F);
    check("postrst_tag",     32'(out_tag), 32'd2);
    drain();

    // Randomized run against a product/tag scoreboard
    sent = 0; got = 0; cyc = 0;
    while ((sent < 1000 || exp_p_q.size() != 0) && cyc < 60000) begin
      accepted = 1'b0;
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_a     = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
        in_b     = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
        in_tag   = TAG_W'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      en        = ($urandom_range(0, 9) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_p_q.size() == 0) begin
          check("rand_spurious_out", 32'd1, 32'd0);
        end else begin
          check("rand_p",   32'(out_p),   32'(exp_p_q.pop_front()));
          check("rand_tag", 32'(out_tag), 32'(exp_t_q.pop_front()));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_p_q.push_back(16'(in_a) * 16'(in_b));
        exp_t_q.push_back(in_tag);
        sent++;
        accepted = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (accepted) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0; en = 1'b1;
    check("rand_sent", 32'(sent), 32'd1000);
    check("rand_got",  32'(got),  32'd1000);
    @(negedge clk);
    check("rand_end_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
